// File: rtl/ch2_wave_gen.sv
// ---------------------------------------------------------------------------
// ch2_wave_gen : channel 2 tone generator.
// Consumes the latched NR21-NR24 fields and the frame-sequencer enables, and
// produces the 4-bit sample for the mixer. Holds the frequency timer, 8-step
// duty sequencer, length counter and volume envelope.
//
// Ports:
//   clk, napu_reset (async, active low)
//   freq_tick / len_tick / env_tick : one-cycle timebase enables
//   duty, len_data, len_wr          : FF16 fields and write strobe
//   init_vol, env_inc, env_period   : FF17 fields
//   freq, len_en, trigger           : FF18/FF19 fields and trigger strobe
//   ch2_out    : registered sample (1-cycle latency)
//   ch2_active : channel enabled status (NR52 bit 1)
//   ch2_ftick  : one-cycle pulse per duty step advance
//
// Optional build macro: CH2_DAC_GATE_EN
//   When defined, init_vol == 0 && env_inc == 0 turns the DAC off, which
//   holds ch2_active low (a trigger still reloads timer/length/envelope).
// ---------------------------------------------------------------------------
module ch2_wave_gen #(
   parameter int unsigned FREQ_W  = 11,
   parameter int unsigned LEN_MAX = 64
) (
   input  logic              clk,
   input  logic              napu_reset,
   input  logic              freq_tick,
   input  logic              len_tick,
   input  logic              env_tick,
   input  logic [1:0]        duty,
   input  logic [5:0]        len_data,
   input  logic              len_wr,
   input  logic [3:0]        init_vol,
   input  logic              env_inc,
   input  logic [2:0]        env_period,
   input  logic [FREQ_W-1:0] freq,
   input  logic              len_en,
   input  logic              trigger,
   output logic [3:0]        ch2_out,
   output logic              ch2_active,
   output logic              ch2_ftick
);

   localparam int unsigned LEN_W = $clog2(LEN_MAX + 1);

   logic [FREQ_W-1:0] ftimer_q, ftimer_d;
   logic [2:0]        step_q,   step_d;
   logic [LEN_W-1:0]  len_q,    len_d;
   logic [3:0]        vol_q,    vol_d;
   logic [2:0]        env_q,    env_d;
   logic              active_q, active_d;
   logic [3:0]        out_q,    out_d;
   logic              ftick_q,  ftick_d;

   logic [7:0]        pattern;
   logic [LEN_W-1:0]  len_load;
   logic [LEN_W-1:0]  len_trig;
   logic [LEN_W-1:0]  len_dec;
   logic [2:0]        env_dec;

   always_comb begin
      case (duty)
         2'b00:   pattern = 8'b1000_0000;
         2'b01:   pattern = 8'b1000_0001;
         2'b10:   pattern = 8'b1110_0001;
         default: pattern = 8'b0111_1110;
      endcase
   end

   assign len_load = LEN_W'(LEN_MAX) - LEN_W'(len_data);
   assign len_dec  = len_q - LEN_W'(1);
   assign env_dec  = env_q - 3'd1;
   // A same-cycle FF16 write lands before the zero-length check of the trigger.
   assign len_trig = len_wr ? len_load : len_q;

   always_comb begin
      ftimer_d = ftimer_q;
      step_d   = step_q;
      len_d    = len_q;
      vol_d    = vol_q;
      env_d    = env_q;
      active_d = active_q;
      ftick_d  = 1'b0;
      out_d    = (active_q && pattern[step_q]) ? vol_q : '0;

      if (trigger) begin
         active_d = 1'b1;
         step_d   = '0;
         ftimer_d = freq;
         vol_d    = init_vol;
         env_d    = env_period;
         len_d    = (len_trig == '0) ? LEN_W'(LEN_MAX) : len_trig;
      end else begin
         if (active_q && freq_tick) begin
            if (ftimer_q == '1) begin
               ftimer_d = freq;
               step_d   = step_q + 3'd1;
               ftick_d  = 1'b1;
            end else begin
               ftimer_d = ftimer_q + FREQ_W'(1);
            end
         end

         if (len_wr) begin
            len_d = len_load;
         end else if (len_tick && len_en && (len_q != '0)) begin
            len_d = len_dec;
            if (len_dec == '0) begin
               active_d = 1'b0;
            end
         end

         if (env_tick && (env_period != 3'd0)) begin
            env_d = env_dec;
            if (env_dec == 3'd0) begin
               env_d = env_period;
               if (env_inc) begin
                  if (vol_q != 4'hF) vol_d = vol_q + 4'd1;
               end else begin
                  if (vol_q != 4'h0) vol_d = vol_q - 4'd1;
               end
            end
         end
      end

`ifdef CH2_DAC_GATE_EN
      if ((init_vol == 4'd0) && !env_inc) begin
         active_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge napu_reset) begin
      if (!napu_reset) begin
         ftimer_q <= '0;
         step_q   <= '0;
         len_q    <= '0;
         vol_q    <= '0;
         env_q    <= '0;
         active_q <= 1'b0;
         out_q    <= '0;
         ftick_q  <= 1'b0;
      end else begin
         ftimer_q <= ftimer_d;
         step_q   <= step_d;
         len_q    <= len_d;
         vol_q    <= vol_d;
         env_q    <= env_d;
         active_q <= active_d;
         out_q    <= out_d;
         ftick_q  <= ftick_d;
      end
   end

   assign ch2_out    = out_q;
   assign ch2_active = active_q;
   assign ch2_ftick  = ftick_q;

endmodule

// File: tb/tb_ch2_wave_gen.sv
module tb_ch2_wave_gen;

   logic        clk = 1'b0;
   logic        napu_reset;
   logic        freq_tick, len_tick, env_tick;
   logic [1:0]  duty;
   logic [5:0]  len_data;
   logic        len_wr;
   logic [3:0]  init_vol;
   logic        env_inc;
   logic [2:0]  env_period;
   logic [10:0] freq;
   logic        len_en;
   logic        trigger;
   logic [3:0]  ch2_out;
   logic        ch2_active;
   logic        ch2_ftick;

   always #5 clk = ~clk;

   ch2_wave_gen #(.FREQ_W(11), .LEN_MAX(64)) dut (
      .clk        (clk),
      .napu_reset (napu_reset),
      .freq_tick  (freq_tick),
      .len_tick   (len_tick),
      .env_tick   (env_tick),
      .duty       (duty),
      .len_data   (len_data),
      .len_wr     (len_wr),
      .init_vol   (init_vol),
      .env_inc    (env_inc),
      .env_period (env_period),
      .freq       (freq),
      .len_en     (len_en),
      .trigger    (trigger),
      .ch2_out    (ch2_out),
      .ch2_active (ch2_active),
      .ch2_ftick  (ch2_ftick)
   );

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 0;

   // Reference model: channel state as plain integers. m_left counts the
   // freq_ticks still needed before the next duty step.
   int m_active, m_left, m_step, m_len, m_vol, m_env, m_out, m_ftick;
   int pat [4][8] = '{ '{0,0,0,0,0,0,0,1},
                       '{1,0,0,0,0,0,0,1},
                       '{1,0,0,0,0,1,1,1},
                       '{0,1,1,1,1,1,1,0} };

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_left = 2048; m_step = 0; m_len = 0;
      m_vol = 0; m_env = 0; m_out = 0; m_ftick = 0;
   endtask

   task automatic model_step();
      int new_out;
      if (!napu_reset) begin
         model_reset();
      end else begin
         new_out = (m_active != 0 && pat[duty][m_step] == 1) ? m_vol : 0;
         m_ftick = 0;
         if (trigger) begin
            if (len_wr) m_len = 64 - int'(len_data);
            if (m_len == 0) m_len = 64;
            m_active = 1;
            m_step   = 0;
            m_left   = 2048 - int'(freq);
            m_vol    = int'(init_vol);
            m_env    = int'(env_period);
         end else begin
            if (m_active != 0 && freq_tick) begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  m_step  = (m_step + 1) % 8;
                  m_left  = 2048 - int'(freq);
                  m_ftick = 1;
               end
            end
            if (len_wr) m_len = 64 - int'(len_data);
            else if (len_tick && len_en && m_len > 0) begin
               m_len = m_len - 1;
               if (m_len == 0) m_active = 0;
            end
            if (env_tick && env_period != 0) begin
               m_env = (m_env + 7) % 8;
               if (m_env == 0) begin
                  m_env = int'(env_period);
                  if (env_inc) m_vol = (m_vol < 15) ? m_vol + 1 : 15;
                  else         m_vol = (m_vol > 0)  ? m_vol - 1 : 0;
               end
            end
         end
`ifdef CH2_DAC_GATE_EN
         if (init_vol == 0 && !env_inc) m_active = 0;
`endif
         m_out = new_out;
      end
   endtask

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("out",    {28'd0, ch2_out},    m_out);
         check("active", {31'd0, ch2_active}, m_active);
         check("ftick",  {31'd0, ch2_ftick},  m_ftick);
      end
   end

   // One clock with the given strobes; returns just after the falling edge.
   task automatic cyc(input bit ft = 0, input bit lt = 0, input bit et = 0,
                      input bit lw = 0, input bit tr = 0);
      freq_tick = ft; len_tick = lt; env_tick = et; len_wr = lw; trigger = tr;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      #1;
      napu_reset = 1'b0;
      model_reset();
      #1;
      check("rst_active", {31'd0, ch2_active}, 0);
      check("rst_out",    {28'd0, ch2_out},    0);
      check("rst_ftick",  {31'd0, ch2_ftick},  0);
      cyc(); cyc();
      napu_reset = 1'b1;
   endtask

   int outs [33];
   int fcount;

   initial begin
      napu_reset = 1'b0;
      freq_tick = 0; len_tick = 0; env_tick = 0; len_wr = 0; trigger = 0;
      duty = 2'b10; len_data = 0; init_vol = 9; env_inc = 0; env_period = 0;
      freq = 11'd2044; len_en = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_active", {31'd0, ch2_active}, 0);
      check("reset_out",    {28'd0, ch2_out},    0);
      napu_reset = 1'b1;
      chk_en = 1;

      // Duty 10 at freq 2044: four ticks per step.
      cyc(.tr(1));
      fcount = 0;
      for (int k = 1; k <= 32; k++) begin
         cyc(.ft(1));
         outs[k] = int'(ch2_out);
         if (ch2_ftick) fcount++;
      end
      check("duty_k1",  outs[1],  9);
      check("duty_k5",  outs[5],  0);
      check("duty_k17", outs[17], 0);
      check("duty_k21", outs[21], 9);
      check("duty_k32", outs[32], 9);
      check("ftick_cnt", fcount, 8);

      // Reset mid-run, then no restart without a trigger.
      pulse_reset();
      repeat (10) cyc(.ft(1), .lt(1), .et(1));
      check("idle_after_rst", {31'd0, ch2_active}, 0);

      // Length expiry after 4 ticks, retrigger reloads 64.
      len_en = 1; len_data = 6'd60;
      cyc(.lw(1));
      cyc(.tr(1));
      for (int i = 1; i <= 4; i++) begin
         cyc(.lt(1));
         if (i == 3) check("len_3rd", {31'd0, ch2_active}, 1);
      end
      check("len_4th", {31'd0, ch2_active}, 0);
      cyc(.tr(1));
      repeat (63) cyc(.lt(1));
      check("len_63", {31'd0, ch2_active}, 1);
      cyc(.lt(1));
      check("len_64", {31'd0, ch2_active}, 0);

      // Envelope up, saturating at 15 (step stays 0, duty 10 bit is set).
      len_en = 0; duty = 2'b10; init_vol = 14; env_inc = 1; env_period = 2;
      cyc(.tr(1)); cyc();
      check("env_up0", {28'd0, ch2_out}, 14);
      cyc(.et(1)); cyc();
      check("env_up1", {28'd0, ch2_out}, 14);
      cyc(.et(1)); cyc();
      check("env_up2", {28'd0, ch2_out}, 15);
      repeat (4) cyc(.et(1));
      cyc();
      check("env_up6", {28'd0, ch2_out}, 15);

      // Envelope down to 0 and held.
      init_vol = 1; env_inc = 0;
      cyc(.tr(1)); cyc();
      check("env_dn0", {28'd0, ch2_out}, 1);
      cyc(.et(1)); cyc(.et(1)); cyc();
      check("env_dn2", {28'd0, ch2_out}, 0);
      repeat (3) cyc(.et(1));
      cyc();
      check("env_dn5", {28'd0, ch2_out}, 0);
      check("env_dn_act", {31'd0, ch2_active}, 1);

      // Collisions.
      init_vol = 7; len_en = 1; len_data = 6'd62;
      cyc(.lw(1));
      cyc(.lt(1), .tr(1));
      cyc(.lt(1));
      check("trig_tick_keep", {31'd0, ch2_active}, 1);
      cyc(.lt(1));
      check("trig_tick_exp", {31'd0, ch2_active}, 0);
      cyc(.tr(1));
      len_data = 6'd63;
      cyc(.lt(1), .lw(1));
      check("wr_tick_keep", {31'd0, ch2_active}, 1);
      cyc(.lt(1));
      check("wr_tick_exp", {31'd0, ch2_active}, 0);

      // DAC gate.
      len_en = 0; init_vol = 0; env_inc = 0;
      cyc(.tr(1));
`ifdef CH2_DAC_GATE_EN
      check("dac_gate", {31'd0, ch2_active}, 0);
`else
      check("dac_gate", {31'd0, ch2_active}, 1);
`endif
      init_vol = 5;

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(19) == 0) begin
            duty       = 2'($urandom);
            len_data   = 6'($urandom_range(63, 40));
            init_vol   = 4'($urandom);
            env_inc    = 1'($urandom);
            env_period = 3'($urandom);
            freq       = ($urandom_range(3) == 0) ? 11'($urandom) : 11'(2040 + $urandom_range(7));
            len_en     = 1'($urandom);
         end
         if (i == 1500) pulse_reset();
         cyc(.ft($urandom_range(1) == 0), .lt($urandom_range(7) == 0),
             .et($urandom_range(7) == 0), .lw($urandom_range(59) == 0),
             .tr($urandom_range(49) == 0));
      end

      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
